// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU request arbiter.
// Opcode/state enums, timeout default and opcode classification.
package tinyalu_pkg;

    localparam int TIMEOUT_CYC_DEF = 31;

    typedef enum logic [2:0] {
        NO_OP  = 3'b000,
        ADD_OP = 3'b001,
        AND_OP = 3'b010,
        XOR_OP = 3'b011,
        MUL_OP = 3'b100
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == ADD_OP) || (op == AND_OP) ||
               (op == XOR_OP) || (op == MUL_OP);
    endfunction

    function automatic logic is_illegal(input logic [2:0] op);
        return op > MUL_OP;
    endfunction

endpackage

// File: rtl/tinyalu_rr_arb.sv
// Two-way round-robin grant; ptr holds the last requester served.
// On a tie the requester that is not ptr wins.
module tinyalu_rr_arb
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] gnt
);

    logic ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b1;
        end else if (upd) begin
            ptr <= upd_id;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = ptr ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one TinyALU between two requesters with round-robin
// grant, ALU timeout, and a held response per owner.
module tinyalu_arbiter
    import tinyalu_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [2:0]  req1_op,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [15:0] resp0_result,
    output logic        resp0_err,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [15:0] resp1_result,
    output logic        resp1_err,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    state_t        state_n;
    logic [1:0]    gnt;
    logic          accept;
    logic          sel;
    logic [2:0]    sel_op;
    logic [7:0]    sel_a;
    logic [7:0]    sel_b;
    logic          owner;
    logic          owner_ready;
    logic          timeout_hit;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [7:0]    a_q;
    logic [7:0]    b_q;
    logic [15:0]   result_q;
    logic          err_q;

    tinyalu_rr_arb u_rr (
        .clk    (clk),
        .reset  (reset),
        .en     (state == IDLE && !reset),
        .req    ({req1_valid, req0_valid}),
        .upd    (state == RESP && owner_ready),
        .upd_id (owner),
        .gnt    (gnt)
    );

    assign req0_ready  = gnt[0];
    assign req1_ready  = gnt[1];
    assign accept      = |gnt;
    assign sel         = gnt[1];
    assign sel_op      = sel ? req1_op : req0_op;
    assign sel_a       = sel ? req1_a  : req0_a;
    assign sel_b       = sel ? req1_b  : req0_b;
    assign owner_ready = owner ? resp1_ready : resp0_ready;
    // This BUSY cycle is the last one allowed; alu_done still wins it.
    assign timeout_hit = (cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = is_alu_op(sel_op) ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (alu_done || timeout_hit) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (owner_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= sel;
                        op_q     <= sel_op;
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        cnt      <= '0;
                        result_q <= '0;
                        err_q    <= is_illegal(sel_op);
                    end
                end
                BUSY: begin
                    if (alu_done) begin
                        result_q <= alu_result;
                        err_q    <= 1'b0;
                    end else if (timeout_hit) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_start    = (state == BUSY);
    assign alu_op       = op_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign resp0_valid  = (state == RESP) && !owner;
    assign resp1_valid  = (state == RESP) && owner;
    assign resp0_result = result_q;
    assign resp1_result = result_q;
    assign resp0_err    = err_q;
    assign resp1_err    = err_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Directed bench for tinyalu_arbiter: grant, latency, timeout,
// backpressure and reset behaviour against hand-computed values.
module tb_tinyalu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [15:0] resp0_result, resp1_result;
    logic        resp0_err, resp1_err;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_done;
    logic [15:0] alu_result;

    int checks = 0;
    int errors = 0;
    int n;
    logic stable;

    always #5 clk = ~clk;

    tinyalu_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_a       (req0_a),
        .req0_b       (req0_b),
        .req0_op      (req0_op),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_a       (req1_a),
        .req1_b       (req1_b),
        .req1_op      (req1_op),
        .resp0_valid  (resp0_valid),
        .resp0_ready  (resp0_ready),
        .resp0_result (resp0_result),
        .resp0_err    (resp0_err),
        .resp1_valid  (resp1_valid),
        .resp1_ready  (resp1_ready),
        .resp1_result (resp1_result),
        .resp1_err    (resp1_err),
        .alu_start    (alu_start),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_done     (alu_done),
        .alu_result   (alu_result)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        resp0_ready = 0; resp1_ready = 0;
        alu_done = 0; alu_result = 0;
        repeat (2) nxt();
        req0_valid = 1; #1;
        chk("rst_ready0", req0_ready, 1'b0);
        reset = 0; req0_valid = 0;
        nxt();
        chk("rst_start", alu_start, 1'b0);
        chk("rst_op", alu_op, 3'd0);
        chk("rst_a", alu_a, 8'd0);
        chk("rst_b", alu_b, 8'd0);
        chk("rst_v0", resp0_valid, 1'b0);
        chk("rst_v1", resp1_valid, 1'b0);
        chk("rst_res0", resp0_result, 16'd0);
        chk("rst_err0", resp0_err, 1'b0);

        // single add, done one cycle after start
        req0_valid = 1; req0_a = 8'hFF; req0_b = 8'h01; req0_op = 3'b001;
        #1;
        chk("add_rdy0", req0_ready, 1'b1);
        chk("add_rdy1", req1_ready, 1'b0);
        nxt(); req0_valid = 0; #1;
        chk("add_start", alu_start, 1'b1);
        chk("add_a", alu_a, 8'hFF);
        chk("add_b", alu_b, 8'h01);
        chk("add_op", alu_op, 3'b001);
        nxt(); alu_done = 1; alu_result = 16'h0100; #1;
        chk("add_start2", alu_start, 1'b1);
        chk("add_v0_early", resp0_valid, 1'b0);
        nxt(); alu_done = 0; #1;
        chk("add_start_off", alu_start, 1'b0);
        chk("add_v0", resp0_valid, 1'b1);
        chk("add_res", resp0_result, 16'h0100);
        chk("add_err", resp0_err, 1'b0);
        chk("add_v1", resp1_valid, 1'b0);
        resp0_ready = 1; nxt(); resp0_ready = 0; #1;
        chk("add_idle", resp0_valid, 1'b0);

        // tie from reset, then alternation
        reset = 1; nxt(); reset = 0;
        req0_valid = 1; req0_a = 8'h10; req0_b = 8'h10; req0_op = 3'b100;
        req1_valid = 1; req1_a = 8'hF0; req1_b = 8'h0F; req1_op = 3'b011;
        #1;
        chk("tie_rdy0", req0_ready, 1'b1);
        chk("tie_rdy1", req1_ready, 1'b0);
        nxt();
        chk("tie_op0", alu_op, 3'b100);
        chk("tie_busy_rdy1", req1_ready, 1'b0);
        alu_done = 1; alu_result = 16'h0100;
        nxt(); alu_done = 0; #1;
        chk("tie_v0", resp0_valid, 1'b1);
        chk("tie_res0", resp0_result, 16'h0100);
        chk("tie_v1", resp1_valid, 1'b0);
        resp0_ready = 1; nxt(); resp0_ready = 0; #1;
        chk("tie_rr_rdy1", req1_ready, 1'b1);
        chk("tie_rr_rdy0", req0_ready, 1'b0);
        nxt();
        chk("tie_op1", alu_op, 3'b011);
        chk("tie_a1", alu_a, 8'hF0);
        alu_done = 1; alu_result = 16'h00FF;
        nxt(); alu_done = 0; #1;
        chk("tie_v1b", resp1_valid, 1'b1);
        chk("tie_res1", resp1_result, 16'h00FF);
        chk("tie_v0b", resp0_valid, 1'b0);
        resp1_ready = 1; nxt(); resp1_ready = 0; #1;
        chk("tie_alt_rdy0", req0_ready, 1'b1);
        chk("tie_alt_rdy1", req1_ready, 1'b0);
        req0_valid = 0; req1_valid = 0;

        // no_op and illegal from req1
        req1_valid = 1; req1_op = 3'b000; req1_a = 8'h05;
        nxt(); req1_valid = 0; #1;
        chk("nop_v1", resp1_valid, 1'b1);
        chk("nop_res", resp1_result, 16'd0);
        chk("nop_err", resp1_err, 1'b0);
        chk("nop_start", alu_start, 1'b0);
        chk("nop_v0", resp0_valid, 1'b0);
        resp1_ready = 1; nxt(); resp1_ready = 0;
        req1_valid = 1; req1_op = 3'b110;
        nxt(); req1_valid = 0; #1;
        chk("ill_v1", resp1_valid, 1'b1);
        chk("ill_err", resp1_err, 1'b1);
        chk("ill_res", resp1_result, 16'd0);
        chk("ill_start", alu_start, 1'b0);
        resp1_ready = 1; nxt(); resp1_ready = 0;

        // timeout: ALU never answers
        req0_valid = 1; req0_op = 3'b001; req0_a = 8'h01; req0_b = 8'h02;
        nxt(); req0_valid = 0;
        n = 0;
        while (alu_start === 1'b1 && n < 40) begin
            n++;
            nxt();
        end
        chk("to_cycles", n, 31);
        chk("to_v0", resp0_valid, 1'b1);
        chk("to_err", resp0_err, 1'b1);
        chk("to_res", resp0_result, 16'd0);
        resp0_ready = 1; nxt(); resp0_ready = 0;

        // done on the 31st BUSY cycle beats the timeout
        req0_valid = 1;
        nxt(); req0_valid = 0;
        repeat (30) nxt();
        chk("late_start", alu_start, 1'b1);
        alu_done = 1; alu_result = 16'h1234;
        nxt(); alu_done = 0; #1;
        chk("late_v0", resp0_valid, 1'b1);
        chk("late_err", resp0_err, 1'b0);
        chk("late_res", resp0_result, 16'h1234);
        resp0_ready = 1; nxt(); resp0_ready = 0;

        // response backpressure; non-owner ready ignored
        req0_valid = 1; req0_a = 8'h03; req0_b = 8'h04;
        nxt(); req0_valid = 0;
        alu_done = 1; alu_result = 16'h0007;
        nxt(); alu_done = 0;
        req1_valid = 1; req1_op = 3'b011; resp1_ready = 1; #1;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(resp0_valid === 1'b1 && resp0_result === 16'h0007 &&
                  req1_ready === 1'b0 && resp1_valid === 1'b0))
                stable = 1'b0;
            nxt();
        end
        resp1_ready = 0;
        chk("bp_stable", stable, 1'b1);
        resp0_ready = 1; #1;
        chk("bp_rdy1_hold", req1_ready, 1'b0);
        nxt(); resp0_ready = 0; #1;
        chk("bp_rdy1", req1_ready, 1'b1);
        chk("bp_v0", resp0_valid, 1'b0);
        req1_valid = 0;

        // reset during BUSY drops the command
        req0_valid = 1; req0_op = 3'b001;
        nxt(); req0_valid = 0; #1;
        chk("mid_busy", alu_start, 1'b1);
        reset = 1; nxt(); reset = 0; #1;
        chk("mid_start", alu_start, 1'b0);
        chk("mid_v0", resp0_valid, 1'b0);
        chk("mid_v1", resp1_valid, 1'b0);
        req0_valid = 1; req1_valid = 1; #1;
        chk("mid_tie0", req0_ready, 1'b1);
        chk("mid_tie1", req1_ready, 1'b0);
        req0_valid = 0; req1_valid = 0;
        repeat (3) nxt();
        chk("mid_v0_late", resp0_valid, 1'b0);
        chk("mid_start_late", alu_start, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/tinyalu_arbiter.md
TINYALU_ARBITER -- requirements
Module: tinyalu_arbiter

Interface
- REQ-001: Parameter TIMEOUT_CYC, default 31; the maximum number of BUSY cycles allowed while waiting for alu_done before the arbiter aborts.
- REQ-002: clk  input  1  single clock; all logic is sampled on its rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: reqN_valid  input  1  requester N (N=0,1) presents a command.
- REQ-005: reqN_ready  output  1  arbiter accepts the command from requester N this cycle.
- REQ-006: reqN_a, reqN_b  input  8 each  operands, unsigned.
- REQ-007: reqN_op  input  3  operation code: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101-111 illegal.
- REQ-008: respN_valid  output  1  a response is pending for requester N.
- REQ-009: respN_ready  input  1  requester N consumes the response.
- REQ-010: respN_result  output  16  result, unsigned.
- REQ-011: respN_err  output  1  the command was illegal or timed out.
- REQ-012: alu_start  output  1  start strobe to the ALU.
- REQ-013: alu_op  output  3  opcode to the ALU.
- REQ-014: alu_a, alu_b  output  8 each  operands to the ALU.
- REQ-015: alu_done  input  1  ALU completion.
- REQ-016: alu_result  input  16  ALU result, valid while alu_done=1.

Function
- REQ-017: The FSM SHALL have the states IDLE, BUSY and RESP.
- REQ-018: In IDLE, the arbiter SHALL assert reqN_ready combinationally for exactly one requester: the valid one, or, when both are valid, the one not granted last (round-robin).
- REQ-019: A command SHALL be accepted on the edge where reqN_valid=1 and reqN_ready=1; its owner, a, b and op SHALL be registered at that edge.
- REQ-020: An accepted op 001-100 SHALL move the FSM IDLE->BUSY.
- REQ-021: In BUSY, alu_start SHALL be 1, and alu_op, alu_a and alu_b SHALL hold the registered values for the whole of BUSY.
- REQ-022: In BUSY with alu_done=1, the arbiter SHALL register alu_result with err=0 and move BUSY->RESP; alu_start SHALL be 0 from the next cycle.
- REQ-023: An accepted no_op SHALL go IDLE->RESP directly with result=0 and err=0; alu_start SHALL stay 0.
- REQ-024: An accepted illegal op (101-111) SHALL go IDLE->RESP directly with result=0 and err=1; alu_start SHALL stay 0.
- REQ-025: A timeout counter SHALL clear on entry to BUSY and increment on each BUSY cycle without alu_done.
- REQ-026: When the timeout counter reaches TIMEOUT_CYC, the FSM SHALL move BUSY->RESP with result=0 and err=1.
- REQ-027: If alu_done and the timeout coincide on the same cycle, alu_done SHALL win (err=0).
- REQ-028: In RESP, only the owner's respN_valid SHALL be 1, and respN_result and respN_err SHALL be stable.
- REQ-029: In RESP, respN_ready=1 SHALL move RESP->IDLE, and the round-robin pointer SHALL be updated to that owner.
- REQ-030: Outside IDLE, both reqN_ready SHALL be 0; new commands wait with no loss.
- REQ-031: Latency SHALL be: accept at edge T; alu_start=1 in cycle T+1; alu_done seen in cycle D; respN_valid=1 in cycle D+1.
- REQ-032: A no_op or illegal response SHALL be valid in cycle T+1.
- REQ-033: Back-to-back operation: a new command MAY be accepted in the cycle immediately following RESP->IDLE.
- REQ-034: respN_ready asserted by the non-owner SHALL be ignored.

Reset
- REQ-035: reset=1 at a rising edge SHALL force IDLE from any state, including mid-BUSY and mid-RESP; an in-flight command SHALL be dropped with no response.
- REQ-036: After reset, alu_start, alu_op, alu_a, alu_b, respN_valid, respN_result and respN_err SHALL all be 0.
- REQ-037: After reset, the timeout counter SHALL be 0 and the round-robin pointer SHALL be 1, so req0 wins the first tie.
- REQ-038: While reset=1, reqN_ready SHALL be 0.

Structure
- REQ-039: The opcode enum operation_t and the FSM state enum SHALL live in tinyalu_pkg.
- REQ-040: The TIMEOUT_CYC default SHALL live in tinyalu_pkg.
- REQ-041: The two-way round-robin grant (pointer register plus grant logic) SHALL be the sub-module tinyalu_rr_arb.
- REQ-042: The timeout counter width SHALL be $clog2(TIMEOUT_CYC+1).

Verification
- REQ-043: Single add: req0 a=8'hFF, b=8'h01, op=001; ALU model asserts done 1 cycle after start with result 16'h0100 -> resp0_valid=1, resp0_result=16'h0100, resp0_err=0; resp1_valid stays 0.
- REQ-044: Tie and fairness: req0 and req1 both valid from reset with mul 8'h10*8'h10 and xor 8'hF0^8'h0F -> req0 is served first (16'h0100), then req1 (16'h00FF); with both kept valid, grants alternate.
- REQ-045: No_op and illegal: req1 op=000 -> resp1 result=0, err=0 in cycle T+1, alu_start never 1; op=110 -> err=1, alu_start never 1.
- REQ-046: Timeout: ALU model never asserts done -> alu_start high for exactly 31 cycles, then resp0_err=1, resp0_result=0; a done asserted on the 31st cycle gives err=0.
- REQ-047: Response backpressure: resp0_ready held 0 for 5 cycles -> resp0_valid and resp0_result stable; req1_ready stays 0 until the response is consumed.
- REQ-048: Reset mid-BUSY: reset=1 for 1 cycle during BUSY -> next cycle IDLE, alu_start=0, no respN_valid; the next tie is granted to req0.
